// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/data memory bus arbiter: FSM states, grant owner, and the
// registered bus command bundle, plus the idle-state arbitration rule.
package mem_bus_arbiter_pkg;

  localparam int unsigned REG_W = 32;

  typedef logic [REG_W-1:0] reg_bus_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_DATA  = 2'd1,
    ARB_FETCH = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

  // Fetches are always full-word reads.
  localparam logic [3:0] FETCH_SEL = 4'hF;

  typedef struct packed {
    logic       we;
    logic [3:0] sel;
    reg_bus_t   addr;
    reg_bus_t   wdata;
  } bus_cmd_t;

  // Data wins a tie unless it won the previous transfer, so neither master can starve.
  function automatic arb_state_e idle_next(input logic   if_req,
                                           input logic   mem_req,
                                           input grant_e last_grant);
    if (mem_req && (!if_req || last_grant == GNT_FETCH)) return ARB_DATA;
    if (if_req) return ARB_FETCH;
    return ARB_IDLE;
  endfunction

  function automatic bus_cmd_t fetch_cmd(input reg_bus_t addr);
    bus_cmd_t cmd;
    cmd.we    = 1'b0;
    cmd.sel   = FETCH_SEL;
    cmd.addr  = addr;
    cmd.wdata = '0;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side and bus-side signals of the arbiter. The arbiter connects through 'slave';
// the surrounding pipeline and bus slave (or a bench) use 'master'.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic       if_req_i;
  reg_bus_t   if_addr_i;
  reg_bus_t   if_rdata_o;
  logic       if_ack_o;

  logic       mem_req_i;
  logic       mem_we_i;
  logic [3:0] mem_sel_i;
  reg_bus_t   mem_addr_i;
  reg_bus_t   mem_wdata_i;
  reg_bus_t   mem_rdata_o;
  logic       mem_ack_o;

  logic       bus_req_o;
  logic       bus_we_o;
  logic [3:0] bus_sel_o;
  reg_bus_t   bus_addr_o;
  reg_bus_t   bus_wdata_o;
  reg_bus_t   bus_rdata_i;
  logic       bus_ack_i;

  logic       stall_req_o;
  logic       bus_err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  bus_rdata_i, bus_ack_i,
    output if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o,
    output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    output stall_req_o, bus_err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output bus_rdata_i, bus_ack_i,
    input  if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o,
    input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    input  stall_req_o, bus_err_o
  );

endinterface

// File: rtl/mem_bus_arbiter_wdog.sv
// Transfer watchdog: up-counter cleared on grant, counting while a transfer is outstanding,
// flagging timeout on the cycle it reaches TIMEOUT_CYC-1. TIMEOUT_CYC = 0 disables it.
module mem_bus_arbiter_wdog #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int unsigned    CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TERM = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_term;

  assign at_term = (cnt_q == TERM);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_term) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: asynchronous reset clears state immediately; flops use <= so they all
  // sample pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (TIMEOUT_CYC != 0) && en_i && at_term;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and data access: round-robin grant,
// registered slave handshake, watchdog abort and a combinational pipeline stall request.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave arb
);

  arb_state_e state_q, state_d;
  grant_e     last_grant_q, last_grant_d;
  bus_cmd_t   bus_cmd_q, bus_cmd_d;
  logic       bus_req_q, bus_req_d;
  reg_bus_t   if_rdata_q, if_rdata_d;
  reg_bus_t   mem_rdata_q, mem_rdata_d;
  logic       if_ack_q, if_ack_d;
  logic       mem_ack_q, mem_ack_d;
  logic       bus_err_q, bus_err_d;

  logic       busy;
  logic       grant_now;
  logic       timeout;
  logic       finish;
  logic       abort;
  reg_bus_t   xfer_rdata;
  bus_cmd_t   data_cmd;

  assign busy      = (state_q == ARB_DATA) || (state_q == ARB_FETCH);
  assign grant_now = (state_q == ARB_IDLE) && (state_d != ARB_IDLE);
  // An ack arriving on the final watchdog cycle still completes the transfer normally.
  assign finish    = busy && (arb.bus_ack_i || timeout);
  assign abort     = busy && timeout && !arb.bus_ack_i;
  assign xfer_rdata = (abort || bus_cmd_q.we) ? '0 : arb.bus_rdata_i;

  assign data_cmd.we    = arb.mem_we_i;
  assign data_cmd.sel   = arb.mem_sel_i;
  assign data_cmd.addr  = arb.mem_addr_i;
  assign data_cmd.wdata = arb.mem_wdata_i;

  mem_bus_arbiter_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (grant_now),
    .en_i      (busy),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GNT_FETCH;
      bus_cmd_q    <= '0;
      bus_req_q    <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      bus_cmd_q    <= bus_cmd_d;
      bus_req_q    <= bus_req_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:            state_d = idle_next(arb.if_req_i, arb.mem_req_i, last_grant_q);
      ARB_DATA, ARB_FETCH: if (finish) state_d = ARB_DONE;
      ARB_DONE:            state_d = ARB_IDLE;
      default:             state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    bus_cmd_d    = bus_cmd_q;
    bus_req_d    = bus_req_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    bus_err_d    = 1'b0;

    if (grant_now) begin
      bus_req_d = 1'b1;
      bus_cmd_d = (state_d == ARB_DATA) ? data_cmd : fetch_cmd(arb.if_addr_i);
    end

    if (finish) begin
      bus_req_d = 1'b0;
      bus_err_d = abort;
      if (state_q == ARB_DATA) begin
        mem_ack_d    = 1'b1;
        mem_rdata_d  = xfer_rdata;
        last_grant_d = GNT_DATA;
      end else begin
        if_ack_d     = 1'b1;
        if_rdata_d   = xfer_rdata;
        last_grant_d = GNT_FETCH;
      end
    end
  end

  assign arb.bus_req_o   = bus_req_q;
  assign arb.bus_we_o    = bus_cmd_q.we;
  assign arb.bus_sel_o   = bus_cmd_q.sel;
  assign arb.bus_addr_o  = bus_cmd_q.addr;
  assign arb.bus_wdata_o = bus_cmd_q.wdata;
  assign arb.if_rdata_o  = if_rdata_q;
  assign arb.if_ack_o    = if_ack_q;
  assign arb.mem_rdata_o = mem_rdata_q;
  assign arb.mem_ack_o   = mem_ack_q;
  assign arb.bus_err_o   = bus_err_q;
  assign arb.stall_req_o = (arb.if_req_i & ~if_ack_q) | (arb.mem_req_i & ~mem_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed stimulus pushes expected bus commands and
// completions; a negedge monitor pops and compares whenever the DUT issues or completes one.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter #(
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus_if)
  );

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_bus_t;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
    logic        err;
  } exp_ack_t;

  exp_bus_t bus_exp_q[$];
  exp_ack_t ack_exp_q[$];
  exp_bus_t mb;
  exp_ack_t ma;
  int       n_checks = 0;
  int       n_pass   = 0;
  logic     prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compares every new bus request and every completion against the scoreboard.
  always @(negedge clk) begin
    if (bus_if.bus_req_o && !prev_req) begin
      if (bus_exp_q.size() == 0) begin
        fail("unexpected bus request");
      end else begin
        mb = bus_exp_q.pop_front();
        check("bus_we_o", 32'(bus_if.bus_we_o), 32'(mb.we));
        check("bus_sel_o", 32'(bus_if.bus_sel_o), 32'(mb.sel));
        check("bus_addr_o", bus_if.bus_addr_o, mb.addr);
        check("bus_wdata_o", bus_if.bus_wdata_o, mb.wdata);
      end
    end
    prev_req = bus_if.bus_req_o;

    if (bus_if.if_ack_o || bus_if.mem_ack_o) begin
      if (bus_if.if_ack_o && bus_if.mem_ack_o) begin
        fail("if_ack_o and mem_ack_o together");
      end else if (ack_exp_q.size() == 0) begin
        fail("unexpected ack");
      end else begin
        ma = ack_exp_q.pop_front();
        check("ack owner (1=data)", 32'(bus_if.mem_ack_o), 32'(ma.is_data));
        check("ack rdata", ma.is_data ? bus_if.mem_rdata_o : bus_if.if_rdata_o, ma.rdata);
        check("bus_err_o with ack", 32'(bus_if.bus_err_o), 32'(ma.err));
      end
    end else if (bus_if.bus_err_o) begin
      fail("bus_err_o without ack");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bus_req();
    int n = 0;
    while (!bus_if.bus_req_o && n < 64) begin
      tick();
      n++;
    end
    if (!bus_if.bus_req_o) fail("timeout waiting for bus_req_o");
  endtask

  // Slave model: acks 'dly' cycles after first seeing bus_req_o; returns in the DONE cycle.
  task automatic slave_ack(input int dly, input logic [31:0] rd);
    wait_bus_req();
    repeat (dly) tick();
    bus_if.bus_ack_i   = 1'b1;
    bus_if.bus_rdata_i = rd;
    tick();
    bus_if.bus_ack_i   = 1'b0;
    bus_if.bus_rdata_i = '0;
  endtask

  task automatic push_fetch(input logic [31:0] addr, input logic [31:0] rdata, input logic err);
    bus_exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: addr, wdata: 32'h0});
    ack_exp_q.push_back('{is_data: 1'b0, rdata: rdata, err: err});
  endtask

  task automatic push_data(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata);
    bus_exp_q.push_back('{we: we, sel: sel, addr: addr, wdata: wdata});
    ack_exp_q.push_back('{is_data: 1'b1, rdata: rdata, err: 1'b0});
  endtask

  task automatic fetch_req(input logic [31:0] addr);
    bus_if.if_req_i  = 1'b1;
    bus_if.if_addr_i = addr;
  endtask

  task automatic data_req(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata);
    bus_if.mem_req_i   = 1'b1;
    bus_if.mem_we_i    = we;
    bus_if.mem_sel_i   = sel;
    bus_if.mem_addr_i  = addr;
    bus_if.mem_wdata_i = wdata;
  endtask

  task automatic idle_inputs();
    bus_if.if_req_i    = 1'b0;
    bus_if.if_addr_i   = '0;
    bus_if.mem_req_i   = 1'b0;
    bus_if.mem_we_i    = 1'b0;
    bus_if.mem_sel_i   = '0;
    bus_if.mem_addr_i  = '0;
    bus_if.mem_wdata_i = '0;
    bus_if.bus_ack_i   = 1'b0;
    bus_if.bus_rdata_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("reset bus_req_o", 32'(bus_if.bus_req_o), 0);
    check("reset bus_addr_o", bus_if.bus_addr_o, 0);
    check("reset bus_sel_o", 32'(bus_if.bus_sel_o), 0);
    check("reset if_ack_o", 32'(bus_if.if_ack_o), 0);
    check("reset mem_ack_o", 32'(bus_if.mem_ack_o), 0);
    check("reset bus_err_o", 32'(bus_if.bus_err_o), 0);
    check("reset if_rdata_o", bus_if.if_rdata_o, 0);
    check("reset mem_rdata_o", bus_if.mem_rdata_o, 0);
    check("reset stall_req_o", 32'(bus_if.stall_req_o), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Fetch only.
    push_fetch(32'h100, 32'h2402_0001, 1'b0);
    fetch_req(32'h100);
    #1;
    check("stall while fetch pending", 32'(bus_if.stall_req_o), 1);
    check("no bus_req_o in request cycle", 32'(bus_if.bus_req_o), 0);
    tick();
    check("bus_req_o one cycle after request", 32'(bus_if.bus_req_o), 1);
    slave_ack(2, 32'h2402_0001);
    check("bus_req_o dropped after ack", 32'(bus_if.bus_req_o), 0);
    check("if_ack_o in ack cycle", 32'(bus_if.if_ack_o), 1);
    check("stall low in fetch ack cycle", 32'(bus_if.stall_req_o), 0);
    bus_if.if_req_i = 1'b0;
    tick();
    check("if_ack_o single pulse", 32'(bus_if.if_ack_o), 0);
    check("stall low after fetch", 32'(bus_if.stall_req_o), 0);
    check("if_rdata_o holds", bus_if.if_rdata_o, 32'h2402_0001);

    // Simultaneous requests from reset: data first, then round-robin hands fetch the tie.
    do_reset();
    push_data(1'b0, 4'hF, 32'h200, 32'h0, 32'hA5A5_0001);
    push_fetch(32'h300, 32'h1111_2222, 1'b0);
    fetch_req(32'h300);
    data_req(1'b0, 4'hF, 32'h200, 32'h0);
    slave_ack(1, 32'hA5A5_0001);
    push_data(1'b0, 4'hC, 32'h204, 32'h0, 32'h5A5A_0002);
    data_req(1'b0, 4'hC, 32'h204, 32'h0);
    slave_ack(1, 32'h1111_2222);
    bus_if.if_req_i = 1'b0;
    slave_ack(1, 32'h5A5A_0002);
    bus_if.mem_req_i = 1'b0;
    tick();

    // Store: bus mirrors the request, load data returns zero.
    push_data(1'b1, 4'b0011, 32'h8, 32'hDEAD_BEEF, 32'h0);
    data_req(1'b1, 4'b0011, 32'h8, 32'hDEAD_BEEF);
    slave_ack(2, 32'h7777_7777);
    idle_inputs();
    tick();

    // Ack on the last watchdog cycle completes without error.
    push_data(1'b0, 4'hF, 32'h40, 32'h0, 32'hCAFE_F00D);
    data_req(1'b0, 4'hF, 32'h40, 32'h0);
    slave_ack(TO - 1, 32'hCAFE_F00D);
    idle_inputs();
    tick();

    // Watchdog abort on a fetch the slave never acks.
    push_fetch(32'h500, 32'h0, 1'b1);
    fetch_req(32'h500);
    tick();
    n = 0;
    while (bus_if.bus_req_o && n < 40) begin
      n++;
      tick();
    end
    check("bus_req_o cycles before abort", 32'(n), TO);
    check("if_ack_o on abort", 32'(bus_if.if_ack_o), 1);
    check("bus_err_o on abort", 32'(bus_if.bus_err_o), 1);
    bus_if.if_req_i = 1'b0;
    tick();
    check("bus_err_o single pulse", 32'(bus_if.bus_err_o), 0);

    // Spurious ack in IDLE is ignored.
    bus_if.bus_ack_i   = 1'b1;
    bus_if.bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus_if.bus_ack_i   = 1'b0;
    bus_if.bus_rdata_i = '0;
    check("spurious ack: no mem_ack_o", 32'(bus_if.mem_ack_o), 0);
    check("spurious ack: no if_ack_o", 32'(bus_if.if_ack_o), 0);
    check("spurious ack: no bus_req_o", 32'(bus_if.bus_req_o), 0);
    check("spurious ack: mem_rdata_o holds", bus_if.mem_rdata_o, 32'hCAFE_F00D);
    push_fetch(32'h600, 32'h0060_0600, 1'b0);
    fetch_req(32'h600);
    tick();
    check("grant right after spurious ack", 32'(bus_if.bus_req_o), 1);
    slave_ack(1, 32'h0060_0600);
    bus_if.if_req_i = 1'b0;
    tick();

    // Reset in the middle of a data transfer.
    bus_exp_q.push_back('{we: 1'b1, sel: 4'hF, addr: 32'h900, wdata: 32'h1234_5678});
    data_req(1'b1, 4'hF, 32'h900, 32'h1234_5678);
    wait_bus_req();
    repeat (2) tick();
    #2 rst = 1'b0;
    #1;
    check("bus_req_o drops on async reset", 32'(bus_if.bus_req_o), 0);
    check("no mem_ack_o on reset", 32'(bus_if.mem_ack_o), 0);
    check("no bus_err_o on reset", 32'(bus_if.bus_err_o), 0);
    idle_inputs();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    push_fetch(32'hA00, 32'h0BAD_C0DE, 1'b0);
    fetch_req(32'hA00);
    tick();
    check("grant after reset restart", 32'(bus_if.bus_req_o), 1);
    slave_ack(1, 32'h0BAD_C0DE);
    bus_if.if_req_i = 1'b0;
    repeat (2) tick();

    check("bus expectations drained", 32'(bus_exp_q.size()), 0);
    check("ack expectations drained", 32'(ack_exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

endmodule
